// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types and default widths for the branch unit and its target table.
//   cond_t   : branch condition encoding carried on br_cond
//   state_t  : branch FSM state (RUN / SQUASH)
//   D_DEF, LUT_AW_DEF, CW_DEF : default PC width, table index width, counter width
//   cond_met : evaluates a condition code against a pair of flags
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int D_DEF      = 12;
    localparam int LUT_AW_DEF = 4;
    localparam int CW_DEF     = 16;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_NZ     = 2'b10,
        COND_N      = 2'b11
    } cond_t;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    function automatic logic cond_met(input cond_t c, input logic z, input logic n);
        logic ok;
        ok = 1'b0;
        case (c)
            COND_ALWAYS: ok = 1'b1;
            COND_Z:      ok = z;
            COND_NZ:     ok = ~z;
            COND_N:      ok = n;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/target_lut.sv
// -----------------------------------------------------------------------------
// target_lut
// Register-array table of signed branch offsets: one synchronous write port,
// one combinational read port, whole array cleared by reset.
//   clk, rst_n  : clock, asynchronous active-low reset
//   we_i        : write enable
//   waddr_i     : write index
//   wdata_i     : offset to store
//   raddr_i     : read index
//   rdata_o     : stored offset at raddr_i (pre-write value on a same-cycle write)
// -----------------------------------------------------------------------------
module target_lut #(
    parameter int D  = 12,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [D-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [D-1:0]  rdata_o
);

    localparam int DEPTH = 2 ** AW;

    logic [D-1:0] mem_q [DEPTH];

    // NOTE: the table is built from flops, not a RAM macro, so it can be
    // cleared by the async reset; a real RAM could not be reset this way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reading the flops directly gives old-data behaviour on a same-cycle write.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Decides each cycle whether the PC takes a relative jump, supplies the jump
// offset from a writable table, and squashes the fetch slot after a taken
// branch (instruction memory has one cycle of read latency).
//   clk, reset              : clock, asynchronous active-low reset
//   instr_valid, br_req     : valid decoded instruction / it is a branch
//   br_cond, lut_idx        : condition code and target table entry
//   flag_we, flag_z_in/n_in : flag register load from the ALU
//   lut_we, lut_waddr/wdata : target table write port
//   jump_en, target         : to PC (PC computes prog_ctr + 1 + target)
//   squash                  : current slot is killed
//   taken_cnt               : saturating count of taken branches
// Build option: define FLAG_BYPASS_EN to let a same-cycle flag load feed the
// condition check directly.
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter int D      = branch_pkg::D_DEF,
    parameter int LUT_AW = branch_pkg::LUT_AW_DEF,
    parameter int CW     = branch_pkg::CW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic              br_req,
    input  logic [1:0]        br_cond,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              flag_we,
    input  logic              flag_z_in,
    input  logic              flag_n_in,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic              jump_en,
    output logic [D-1:0]      target,
    output logic              squash,
    output logic [CW-1:0]     taken_cnt
);

    import branch_pkg::*;

    logic          flag_z_q;
    logic          flag_n_q;
    state_t        state_q;
    logic [CW-1:0] taken_cnt_q;
    logic [D-1:0]  lut_rdata;
    logic          eval_z;
    logic          eval_n;
    logic          take;

    target_lut #(
        .D  (D),
        .AW (LUT_AW)
    ) u_target_lut (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (lut_we),
        .waddr_i (lut_waddr),
        .wdata_i (lut_wdata),
        .raddr_i (lut_idx),
        .rdata_o (lut_rdata)
    );

`ifdef FLAG_BYPASS_EN
    // A compare immediately followed by a branch resolves with the fresh flags.
    assign eval_z = flag_we ? flag_z_in : flag_z_q;
    assign eval_n = flag_we ? flag_n_in : flag_n_q;
`else
    assign eval_z = flag_z_q;
    assign eval_n = flag_n_q;
`endif

    // Gating with reset keeps jump_en/target low for the whole reset window,
    // not just after the first edge.
    assign take = reset & (state_q == RUN) & instr_valid & br_req
                & cond_met(cond_t'(br_cond), eval_z, eval_n);

    assign jump_en   = take;
    assign target    = take ? lut_rdata : '0;
    assign squash    = (state_q == SQUASH);
    assign taken_cnt = taken_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (flag_we) begin
            flag_z_q <= flag_z_in;
            flag_n_q <= flag_n_in;
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge value of take, not a partially updated one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            taken_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN:     if (take) state_q <= SQUASH;
                SQUASH:  state_q <= RUN;
                default: state_q <= RUN;
            endcase
            if (take && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Control-side partner of the program counter: decides each cycle whether the PC takes a relative jump.
- Drives the PC's jump_en/target inputs from the decoded branch request, the registered condition flags and a writable target-offset lookup table.
- Instruction memory has 1-cycle read latency, so the slot fetched after a taken branch is squashed by a small FSM.
- Sits between the decoder/ALU flag outputs and the PC.

Parameters:
- D, 12, PC/target width; must equal the PC's D.
- LUT_AW, 4, target table index width (2**LUT_AW entries).
- CW, 16, taken-branch counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_valid  input  1  current decoded instruction is valid.
- br_req  input  1  current instruction is a branch.
- br_cond  input  2  00 always, 01 Z set, 10 Z clear, 11 N set.
- lut_idx  input  LUT_AW  target table entry selected by the branch.
- flag_we  input  1  load flag register.
- flag_z_in  input  1  zero flag from ALU.
- flag_n_in  input  1  negative flag from ALU.
- lut_we  input  1  write target table.
- lut_waddr  input  LUT_AW  table write index.
- lut_wdata  input  D  two's-complement offset to store.
- jump_en  output  1  to PC: take relative jump this edge.
- target  output  D  to PC: offset; PC computes prog_ctr+1+target.
- squash  output  1  current instruction slot is killed (decoder must suppress writes).
- taken_cnt  output  CW  count of taken branches.

Behaviour:
- Reset (reset low, async): flags Z=N=0, all LUT entries 0, state RUN, taken_cnt 0. jump_en=0, squash=0 and target=0 for as long as reset is low.
- Flags: on a rising edge with flag_we=1, Z<=flag_z_in and N<=flag_n_in; otherwise held. Branch evaluation uses the registered flags, so a same-cycle flag_we is not seen (unless FLAG_BYPASS_EN).
- Condition: cond_ok = (br_cond==00) | (01 & Z) | (10 & ~Z) | (11 & N).
- take = (state==RUN) & instr_valid & br_req & cond_ok.
- jump_en = take, combinational; the PC samples it at the next edge. No added latency.
- target = lut[lut_idx] whenever take=1; otherwise 0.
- LUT: combinational read, synchronous write. A same-cycle write and read of the same index returns the old value.
- FSM states: RUN, SQUASH.
  - RUN -> SQUASH on take.
  - RUN -> RUN otherwise.
  - SQUASH -> RUN unconditionally after 1 cycle.
- In SQUASH: squash=1, jump_en=0, and br_req is ignored (a branch in the shadow slot is never taken). flag_we and lut_we still act; the decoder is responsible for gating them with squash.
- squash=0 in RUN.
- taken_cnt: +1 on each edge where take=1; saturates at all-ones (no wrap).
- Back-to-back taken branches cannot occur; the minimum spacing of 2 cycles is enforced by SQUASH.
- Reset mid-SQUASH returns immediately to RUN with squash=0.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: when flag_we=1 in the evaluation cycle, cond_ok uses flag_z_in/flag_n_in instead of the registered flags, so a compare immediately followed by a branch resolves in the same cycle.
- Undefined: registered flags only; software must place one instruction between the flag-setting op and the branch.
- Neither setting changes the port list.

Decomposition:
- branch_pkg holds:
  - cond_t enum: COND_ALWAYS, COND_Z, COND_NZ, COND_N.
  - state_t enum: RUN, SQUASH.
  - Default width constants D=12, LUT_AW=4.
- One sub-module, target_lut: 2**LUT_AW x D register array with async-reset clear, 1 sync write port, 1 comb read port.
- FSM, flags and counter stay in branch_unit.

Test Plan:
- Reset low mid-run with taken_cnt=5, state SQUASH -> all outputs 0, state RUN; after release, unconditional branch with lut[3]=12'h005 -> jump_en=1, target=12'h005.
- Write lut[2]=12'hFFC (-4), flags Z=1, branch cond 01 idx 2 -> jump_en=1, target=12'hFFC; next cycle squash=1; same branch with Z=0 -> jump_en=0, squash stays 0.
- Two consecutive branch instructions, both cond 00 -> first gives jump_en=1; second (shadow slot) gives jump_en=0, squash=1; taken_cnt increments by 1 only.
- flag_we with flag_z_in=1 in the same cycle as a cond-01 branch, old Z=0 -> jump_en=0 without FLAG_BYPASS_EN; jump_en=1 with it.
- lut_we to idx 7 with value 12'h010 in the same cycle as a branch reading idx 7 (old value 12'h001) -> target=12'h001; the next branch on idx 7 gives 12'h010.
- Force taken_cnt to 16'hFFFE, then 3 taken branches -> count reads FFFF and holds; instr_valid=0 with br_req=1 -> no jump.
